// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   OP_W            opcode width
//   Op*             opcode encodings
//   Flag*           bit positions of N/V/Z/C inside flag_we and the flag register
//   alu_state_e     control FSM encoding
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OpAdd  = 4'h0;
  localparam logic [OP_W-1:0] OpSub  = 4'h1;
  localparam logic [OP_W-1:0] OpAnd  = 4'h2;
  localparam logic [OP_W-1:0] OpOr   = 4'h3;
  localparam logic [OP_W-1:0] OpEor  = 4'h4;
  localparam logic [OP_W-1:0] OpAsl  = 4'h5;
  localparam logic [OP_W-1:0] OpLsr  = 4'h6;
  localparam logic [OP_W-1:0] OpRol  = 4'h7;
  localparam logic [OP_W-1:0] OpRor  = 4'h8;
  localparam logic [OP_W-1:0] OpCmp  = 4'h9;
  localparam logic [OP_W-1:0] OpPass = 4'hA;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagC = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StBcd,
    StHold
  } alu_state_e;

endpackage

// File: rtl/bcd_digit.sv
// Combinational single-digit BCD add/subtract cell.
//   a_i, b_i  operand nibbles
//   c_i       incoming carry (add) / not-borrow (sub)
//   sub_i     1 = subtract
//   digit_o   corrected result nibble
//   c_o       outgoing carry (add) / not-borrow (sub)
// Non-decimal input nibbles follow the same rules; no error is flagged.
module bcd_digit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [3:0] digit_o,
  output logic       c_o
);

  logic [4:0] raw;

  always_comb begin
    raw     = 5'd0;
    digit_o = 4'd0;
    c_o     = 1'b0;
    if (sub_i) begin
      // Range is -16..15, so bit 4 is the sign of the 5-bit difference.
      raw = {1'b0, a_i} - {1'b0, b_i} - {4'd0, ~c_i};
      if (raw[4]) begin
        digit_o = raw[3:0] - 4'd6;
        c_o     = 1'b0;
      end else begin
        digit_o = raw[3:0];
        c_o     = 1'b1;
      end
    end else begin
      raw = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
      if (raw > 5'd9) begin
        digit_o = raw[3:0] + 4'd6;
        c_o     = 1'b1;
      end else begin
        digit_o = raw[3:0];
        c_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
//   phi1, reset_n           clock, async active-low reset
//   in_valid/in_ready       request handshake; a, b, op, carry_in, dec_mode sampled on accept
//   out_valid/out_ready     result handshake; outputs frozen while out_valid is high
//   result, flag_n/v/z/c    result and computed flags
//   flag_we {N,V,Z,C}       flag update enables; res_we destination write enable
//   half_carry              binary carry out of bit 3
// Binary ops finish in EXEC; decimal ADD/SUB then run one BCD digit per cycle.
module alu_seq import alu_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             phi1,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             carry_in,
  input  logic             dec_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_c,
  output logic [3:0]       flag_we,
  output logic             res_we,
  output logic             half_carry
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned CntW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             cin_q, cin_d, dec_q, dec_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bc_q, bc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       fwe_q, fwe_d;
  logic             rwe_q, rwe_d, hc_q, hc_d;

  // Binary datapath
  logic [WIDTH-1:0] bx;
  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bin_r;
  logic             bin_c, bin_v, bin_hc, bin_rwe;
  logic [3:0]       bin_fwe;
  logic             is_dec, last_digit;

  // Digit-serial decimal path
  logic [3:0]       dig_a, dig_b, dig_r;
  logic             dig_c;

  always_comb begin
    bx      = (op_q == OpSub || op_q == OpCmp) ? ~b_q : b_q;
    cin_eff = (op_q == OpCmp) ? 1'b1 : cin_q;
    sum     = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, cin_eff};
    bin_r   = a_q;
    bin_c   = 1'b0;
    bin_v   = 1'b0;
    bin_hc  = 1'b0;
    bin_fwe = 4'b0000;
    bin_rwe = 1'b0;
    case (op_q)
      OpAdd, OpSub, OpCmp: begin
        bin_r   = sum[WIDTH-1:0];
        bin_c   = sum[WIDTH];
        bin_v   = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        bin_hc  = ({1'b0, a_q[3:0]} + {1'b0, bx[3:0]} + {4'd0, cin_eff}) > 5'd15;
        bin_fwe = (op_q == OpCmp) ? 4'b1011 : 4'b1111;
        bin_rwe = (op_q != OpCmp);
      end
      OpAnd:  begin bin_r = a_q & b_q; bin_fwe = 4'b1010; bin_rwe = 1'b1; end
      OpOr:   begin bin_r = a_q | b_q; bin_fwe = 4'b1010; bin_rwe = 1'b1; end
      OpEor:  begin bin_r = a_q ^ b_q; bin_fwe = 4'b1010; bin_rwe = 1'b1; end
      OpAsl: begin
        bin_r = {a_q[WIDTH-2:0], 1'b0};  bin_c = a_q[WIDTH-1];
        bin_fwe = 4'b1011;               bin_rwe = 1'b1;
      end
      OpLsr: begin
        bin_r = {1'b0, a_q[WIDTH-1:1]};  bin_c = a_q[0];
        bin_fwe = 4'b1011;               bin_rwe = 1'b1;
      end
      OpRol: begin
        bin_r = {a_q[WIDTH-2:0], cin_q}; bin_c = a_q[WIDTH-1];
        bin_fwe = 4'b1011;               bin_rwe = 1'b1;
      end
      OpRor: begin
        bin_r = {cin_q, a_q[WIDTH-1:1]}; bin_c = a_q[0];
        bin_fwe = 4'b1011;               bin_rwe = 1'b1;
      end
      OpPass: begin bin_fwe = 4'b1010; bin_rwe = 1'b1; end
      default: ;
    endcase
  end

  assign is_dec     = dec_q && (op_q == OpAdd || op_q == OpSub);
  assign last_digit = (cnt_q == CntW'(DIGITS - 1));

  always_comb begin
    dig_a = a_q[{cnt_q, 2'b00} +: 4];
    dig_b = b_q[{cnt_q, 2'b00} +: 4];
  end

  bcd_digit u_bcd_digit (
    .a_i     (dig_a),
    .b_i     (dig_b),
    .c_i     (bc_q),
    .sub_i   (op_q == OpSub),
    .digit_o (dig_r),
    .c_o     (dig_c)
  );

  // FSM: state register
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StExec;
      StExec: state_d = is_dec ? StBcd : StHold;
      StBcd:  if (last_digit) state_d = StHold;
      StHold: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StHold);
  end

  // Datapath next state; registers only move in IDLE (capture), EXEC and BCD,
  // which keeps every output frozen during HOLD.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    dec_d    = dec_q;
    cnt_d    = cnt_q;
    bc_d     = bc_q;
    result_d = result_q;
    flags_d  = flags_q;
    fwe_d    = fwe_q;
    rwe_d    = rwe_q;
    hc_d     = hc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          op_d  = op;
          cin_d = carry_in;
          dec_d = dec_mode;
        end
      end
      StExec: begin
        result_d       = bin_r;
        flags_d[FlagN] = bin_r[WIDTH-1];
        flags_d[FlagV] = bin_v;
        flags_d[FlagZ] = (bin_r == '0);
        flags_d[FlagC] = bin_c;
        fwe_d          = bin_fwe;
        rwe_d          = bin_rwe;
        hc_d           = bin_hc;
        cnt_d          = '0;
        bc_d           = cin_q;
      end
      StBcd: begin
        result_d[{cnt_q, 2'b00} +: 4] = dig_r;
        bc_d  = dig_c;
        cnt_d = cnt_q + CntW'(1);
        if (last_digit) flags_d[FlagC] = dig_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      dec_q    <= 1'b0;
      cnt_q    <= '0;
      bc_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      fwe_q    <= 4'b0000;
      rwe_q    <= 1'b0;
      hc_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      dec_q    <= dec_d;
      cnt_q    <= cnt_d;
      bc_q     <= bc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      fwe_q    <= fwe_d;
      rwe_q    <= rwe_d;
      hc_q     <= hc_d;
    end
  end

  assign result     = result_q;
  assign flag_n     = flags_q[FlagN];
  assign flag_v     = flags_q[FlagV];
  assign flag_z     = flags_q[FlagZ];
  assign flag_c     = flags_q[FlagC];
  assign flag_we    = fwe_q;
  assign res_we     = rwe_q;
  assign half_carry = hc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for most vectors and a
// 16-bit instance for the four-digit decimal carry chain.
module tb_alu_seq;
  import alu_pkg::*;

  logic phi1, reset_n;

  // 8-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, result;
  logic [3:0]  op, flag_we;
  logic        carry_in, dec_mode, flag_n, flag_v, flag_z, flag_c, res_we, half_carry;

  // 16-bit instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  op16, flag_we16;
  logic        carry_in16, dec_mode16, flag_n16, flag_v16, flag_z16, flag_c16;
  logic        res_we16, half_carry16;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  alu_seq #(.WIDTH(8)) u_dut (
    .phi1(phi1), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .carry_in(carry_in), .dec_mode(dec_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .flag_c(flag_c),
    .flag_we(flag_we), .res_we(res_we), .half_carry(half_carry)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .phi1(phi1), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .carry_in(carry_in16), .dec_mode(dec_mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .flag_n(flag_n16), .flag_v(flag_v16), .flag_z(flag_z16), .flag_c(flag_c16),
    .flag_we(flag_we16), .res_we(res_we16), .half_carry(half_carry16)
  );

  initial begin
    phi1 = 1'b0;
    forever #5 phi1 = ~phi1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request on the 8-bit instance and wait (bounded) for out_valid.
  // lat counts active edges after the acceptance edge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] top,
                      input logic tc, input logic td);
    a = ta; b = tb_; op = top; carry_in = tc; dec_mode = td;
    in_valid = 1'b1;
    @(posedge phi1); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge phi1); #1;
      lat++;
    end
  endtask

  task automatic release8();
    out_ready = 1'b1;
    @(posedge phi1); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0; carry_in = 0; dec_mode = 0;
    in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; op16 = 0;
    carry_in16 = 0; dec_mode16 = 0;
    #12;
    chk("rst_result", result, 8'h00);
    chk("rst_flags", {flag_n, flag_v, flag_z, flag_c}, 4'b0000);
    chk("rst_we", {flag_we, res_we, half_carry}, 6'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge phi1); reset_n = 1'b1;
    @(posedge phi1); #1;

    // Binary ADD with signed overflow
    run8(8'h50, 8'h50, OpAdd, 1'b0, 1'b0);
    chk("add_lat", lat, 1);
    chk("add_result", result, 8'hA0);
    chk("add_nvzc", {flag_n, flag_v, flag_z, flag_c}, 4'b1100);
    chk("add_hc", half_carry, 1'b0);
    chk("add_fwe", flag_we, 4'b1111);
    chk("add_rwe", res_we, 1'b1);
    chk("add_in_ready", in_ready, 1'b0);
    release8();
    chk("add_idle", {in_ready, out_valid}, 2'b10);

    // Half carry out of bit 3
    run8(8'h0F, 8'h01, OpAdd, 1'b0, 1'b0);
    chk("hc_result", result, 8'h10);
    chk("hc_flag", half_carry, 1'b1);
    chk("hc_nvzc", {flag_n, flag_v, flag_z, flag_c}, 4'b0000);
    release8();

    // Decimal ADD: 58 + 46 + 1 = 105 -> 05, C=1; N/V from binary 0x9F
    run8(8'h58, 8'h46, OpAdd, 1'b1, 1'b1);
    chk("dadd_lat", lat, 3);
    chk("dadd_result", result, 8'h05);
    chk("dadd_c", flag_c, 1'b1);
    chk("dadd_nvz", {flag_n, flag_v, flag_z}, 3'b110);
    release8();

    // Decimal SUB: 12 - 21 = -9 -> 91, C=0; N from binary 0xF1
    run8(8'h12, 8'h21, OpSub, 1'b1, 1'b1);
    chk("dsub_lat", lat, 3);
    chk("dsub_result", result, 8'h91);
    chk("dsub_c", flag_c, 1'b0);
    chk("dsub_n", flag_n, 1'b1);
    chk("dsub_rwe", res_we, 1'b1);
    chk("dsub_fwe", flag_we, 4'b1111);
    release8();

    // ROR with carry fill
    run8(8'h01, 8'h00, OpRor, 1'b1, 1'b0);
    chk("ror_result", result, 8'h80);
    chk("ror_nzc", {flag_n, flag_z, flag_c}, 3'b101);
    chk("ror_fwe", flag_we, 4'b1011);
    release8();

    // ASL drops the msb into C
    run8(8'h81, 8'h00, OpAsl, 1'b1, 1'b0);
    chk("asl_result", result, 8'h02);
    chk("asl_c", flag_c, 1'b1);
    release8();

    // CMP equal; decimal mode must not affect CMP
    run8(8'h10, 8'h10, OpCmp, 1'b0, 1'b1);
    chk("cmp_lat", lat, 1);
    chk("cmp_nzc", {flag_n, flag_z, flag_c}, 3'b011);
    chk("cmp_rwe", res_we, 1'b0);
    chk("cmp_fwe", flag_we, 4'b1011);
    release8();

    // Undefined opcode: pass-through with no enables
    run8(8'h3C, 8'h00, 4'hD, 1'b0, 1'b0);
    chk("undef_result", result, 8'h3C);
    chk("undef_we", {flag_we, res_we}, 5'b0);
    release8();

    // Backpressure: AND result held for 5 cycles while inputs churn
    run8(8'hF0, 8'h3C, OpAnd, 1'b0, 1'b0);
    chk("and_result", result, 8'h30);
    chk("and_fwe", flag_we, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      op = 4'($urandom);
      in_valid = i[0];
      @(posedge phi1); #1;
      chk("hold_result", result, 8'h30);
      chk("hold_state", {out_valid, in_ready}, 2'b10);
      chk("hold_fwe", flag_we, 4'b1010);
    end
    a = 8'h01; b = 8'h02; op = OpAdd; carry_in = 0; dec_mode = 0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge phi1); #1;
    out_ready = 1'b0;
    chk("post_hold_ready", in_ready, 1'b1);
    @(posedge phi1); #1;
    in_valid = 1'b0;
    chk("post_hold_accept", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge phi1); #1;
      lat++;
    end
    chk("post_hold_lat", lat, 1);
    chk("post_hold_result", result, 8'h03);
    release8();

    // 16-bit decimal carry chain: 9999 + 0001 = 0000, C=1
    a16 = 16'h9999; b16 = 16'h0001; op16 = OpAdd; carry_in16 = 0; dec_mode16 = 1;
    in_valid16 = 1'b1;
    @(posedge phi1); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge phi1); #1;
      lat++;
    end
    chk("d16_lat", lat, 5);
    chk("d16_result", result16, 16'h0000);
    chk("d16_c", flag_c16, 1'b1);
    out_ready16 = 1'b1;
    @(posedge phi1); #1;
    out_ready16 = 1'b0;

    // Reset during BCD digit 1
    a = 8'h58; b = 8'h46; op = OpAdd; carry_in = 1; dec_mode = 1; in_valid = 1'b1;
    @(posedge phi1); #1;                // accepted, EXEC
    in_valid = 1'b0;
    @(posedge phi1); #1;                // BCD digit 0
    @(posedge phi1); #1;                // BCD digit 1
    chk("mid_bcd_busy", {out_valid, in_ready}, 2'b00);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_flags", {flag_n, flag_v, flag_z, flag_c, flag_we, res_we, half_carry}, 10'b0);
    chk("mid_rst_state", {out_valid, in_ready}, 2'b01);
    @(negedge phi1); reset_n = 1'b1;
    @(posedge phi1); #1;
    chk("post_rst_ready", in_ready, 1'b1);
    run8(8'h01, 8'h01, OpAdd, 1'b0, 1'b0);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_result", result, 8'h02);
    release8();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised successor to the 6502 ALU. Accepts one operation per valid/ready handshake, computes binary results in one cycle and decimal-mode ADD/SUB digit-serially (one BCD nibble per cycle). Returns the result with NVZC flags and write-enables to the register/status logic. It sits between the decode/sequencer and the accumulator/status register, and adds backpressure, decimal mode and shifts/rotates.

## Interface
- `WIDTH`, 8, operand/result width; must be a multiple of 4 and at least 4.
- `DIGITS`, `WIDTH/4`, derived; BCD digit count (localparam, not overridable).
- `phi1` in 1: sole clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when both are high at an edge; equals (state==IDLE).
- `a`, `b` in WIDTH: operands; shifts/rotates use `a` only.
- `op` in `OP_W` (4): opcode from alu_pkg.
- `carry_in` in 1: C flag input; ADD/SUB carry, ROL/ROR fill bit.
- `dec_mode` in 1: D flag; affects ADD/SUB only.
- `out_valid` out 1: result held valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: operation result.
- `flag_n`, `flag_v`, `flag_z`, `flag_c` out 1 each: computed flags.
- `flag_we` out 4: {N,V,Z,C} update enables.
- `res_we` out 1: destination write enable.
- `half_carry` out 1: binary carry out of bit 3.

## Operation
- FSM: IDLE → EXEC → (BCD) → HOLD → IDLE.
- IDLE: when `in_valid`, latch `a`, `b`, `op`, `carry_in` and `dec_mode` → EXEC.
- EXEC: compute the binary result and all flags into output registers.
  - If `dec_mode` and op is ADD or SUB: clear the digit counter → BCD.
  - Otherwise → HOLD.
- BCD: process digit i (LSB first).
  - ADD: s = a_i + b_i + c; if s > 9 then s += 6 and c = 1, else c = 0.
  - SUB: d = a_i − b_i − ~c; if d < 0 then d −= 6 and c = 0, else c = 1.
  - Write digit i of `result`. After digit DIGITS−1: `flag_c` = c → HOLD.
- HOLD: `out_valid` = 1, and all outputs are stable. When `out_ready` → IDLE.
- Opcode semantics (b' = b for ADD, ~b for SUB/CMP):
  - ADD 0x0 and SUB 0x1: r = a + b' + carry_in; C = carry out; V = (a[msb]==b'[msb]) & (r[msb]!=a[msb]); flag_we 1111, res_we 1.
  - AND 0x2, OR 0x3, EOR 0x4: flag_we 1010.
  - ASL 0x5: shift left, 0 in, C = a[msb]. LSR 0x6: shift right, 0 in, C = a[0]. ROL 0x7: shift left, carry_in in. ROR 0x8: shift right, carry_in at msb. All shifts/rotates: flag_we 1011.
  - CMP 0x9: r = a + ~b + 1; flag_we 1011, res_we 0.
  - PASS 0xA: r = a; flag_we 1010.
  - 0xB–0xF: r = a, flag_we 0000, res_we 0.
- N = r[msb], Z = (r == 0) for all ops.
- In decimal mode, N, Z and V come from the binary computation in EXEC. Only `result` and `flag_c` are decimal. This matches NMOS behaviour.
- Invalid BCD digits (>9) are processed by the same rules with no error.
- `half_carry` is taken from the binary sum in every mode.

## Timing
- Acceptance edge E0. EXEC evaluates at E1.
- Binary ops: `out_valid` goes high after E1, i.e. 1 cycle after acceptance (latency 2 edges including E0).
- Decimal ADD/SUB: `out_valid` goes high after E1+DIGITS. Default 8-bit: E3.
- `in_ready` is low from E0 until the cycle after the HOLD handshake edge. There is no overlap and no bypass, so maximum throughput is one op per 3 cycles.
- `in_valid` while not IDLE is ignored; operands are not re-sampled.
- Outputs must not change while in HOLD, regardless of input activity.
- Reset values: `result` 0, all flags 0, `flag_we` 0, `res_we` 0, `half_carry` 0, `out_valid` 0, state IDLE, `in_ready` 1.
- Reset asserted in any state, including mid-BCD, clears everything immediately; the in-flight op is lost.

## Structure
- `alu_pkg`: `OP_W`, opcode constants, flag index constants (N=3, V=2, Z=1, C=0) and FSM state encoding.
- Sub-module `bcd_digit`: combinational 4-bit decimal add/sub cell (a_i, b_i, c, sub → digit, c_out). Instantiated once and time-multiplexed by the digit counter.

## Test plan
- Binary ADD, a=0x50, b=0x50, c=0 → result 0xA0, N1 V1 Z0 C0, half_carry 0, flag_we 1111, out_valid one cycle after acceptance.
- Decimal ADD, a=0x58, b=0x46, c=1 → result 0x05, C1, out_valid at E3; with WIDTH=16, a=0x9999, b=0x0001, c=0 → 0x0000, C1 at E5.
- Decimal SUB, a=0x12, b=0x21, c=1 → result 0x91, C0, res_we 1.
- ROR, a=0x01, carry_in=1 → 0x80, N1 Z0 C1, flag_we 1011. CMP, a=0x10, b=0x10 → Z1 C1 N0, res_we 0.
- Hold `out_ready` low for 5 cycles in HOLD while toggling `a`/`op`/`in_valid` → outputs stable and `in_ready` 0; then raise `out_ready` → next request accepted the following cycle.
- Assert `reset_n` low during BCD digit 1 of a decimal ADD → all outputs 0 asynchronously. After release, `in_ready` is 1 and a fresh ADD 0x01+0x01 gives 0x02.
